mult_unit: RTL

- Iterative radix-2 shift-add multiplier in the EX stage; executes MIPS mult/multu and owns the HI/LO registers.
- Driven by the EX-stage start strobe (MultStartE).
- Its prod_valid output is the ProdVE input of the hazard unit, which holds StallE high until prod_valid rises.
- Fixed latency; one operation in flight.

---
 rtl/mult_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MIPS mult/multu.
// Owns the HI/LO registers and runs one operation at a time with a fixed latency.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             prod_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + 1;

    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P      = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CW-1:0]     count_r;
    logic [AW-1:0]     acc_r;
    logic [WIDTH-1:0]  mcand_r;
    logic              neg_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;
    logic              busy_r;
    logic              prod_valid_r;

    logic              busy_next_s;
    logic              prod_valid_next_s;
    logic              load_s;
    logic [WIDTH-1:0]  mag_a_s;
    logic [WIDTH-1:0]  mag_b_s;
    logic [WIDTH:0]    add_s;
    logic [AW-1:0]     partial_s;
    logic [AW-1:0]     acc_step_s;
    logic [PW-1:0]     product_s;

    // Two's-complement magnitude; the most negative value maps onto itself as an unsigned number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = ~v + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush in IDLE also masks a simultaneous start.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start && !flush) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else if (count_r == LAST_COUNT) begin
                    next_state_s = S_FIX;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_FIX: begin
                if (flush) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/prod_valid come straight from flops.
    always_comb begin
        busy_next_s       = 1'b0;
        prod_valid_next_s = 1'b0;
        case (next_state_s)
            S_IDLE: begin
                busy_next_s       = 1'b0;
                prod_valid_next_s = 1'b0;
            end
            S_RUN, S_FIX: begin
                busy_next_s       = 1'b1;
                prod_valid_next_s = 1'b0;
            end
            S_DONE: begin
                busy_next_s       = 1'b1;
                prod_valid_next_s = 1'b1;
            end
            default: begin
                busy_next_s       = 1'b0;
                prod_valid_next_s = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            prod_valid_r <= 1'b0;
        end else begin
            busy_r       <= busy_next_s;
            prod_valid_r <= prod_valid_next_s;
        end
    end

    // Operand conditioning and one shift-add step.
    always_comb begin
        load_s  = (state_r == S_IDLE) && start && !flush;
        mag_a_s = is_signed ? magnitude(srca) : srca;
        mag_b_s = is_signed ? magnitude(srcb) : srcb;
        add_s   = acc_r[AW-1:WIDTH] + {1'b0, mcand_r};
        if (acc_r[0]) begin
            partial_s = {add_s, acc_r[WIDTH-1:0]};
        end else begin
            partial_s = acc_r;
        end
        acc_step_s = {1'b0, partial_s[AW-1:1]};
        if (neg_r) begin
            product_s = ~acc_r[PW-1:0] + ONE_P;
        end else begin
            product_s = acc_r[PW-1:0];
        end
    end

    // Iteration datapath: operand load in IDLE, one iteration per RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
            acc_r   <= {AW{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (load_s) begin
                        count_r <= {CW{1'b0}};
                        acc_r   <= {1'b0, {WIDTH{1'b0}}, mag_b_s};
                        mcand_r <= mag_a_s;
                        neg_r   <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    end else begin
                        count_r <= count_r;
                        acc_r   <= acc_r;
                        mcand_r <= mcand_r;
                        neg_r   <= neg_r;
                    end
                end
                S_RUN: begin
                    count_r <= count_r + COUNT_ONE;
                    acc_r   <= acc_step_s;
                end
                default: begin
                    count_r <= count_r;
                    acc_r   <= acc_r;
                end
            endcase
        end
    end

    // HI/LO commit, only on a FIX cycle that is not being flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if ((state_r == S_FIX) && !flush) begin
            hi_r <= product_s[PW-1:WIDTH];
            lo_r <= product_s[WIDTH-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign busy       = busy_r;
    assign prod_valid = prod_valid_r;
    assign hi         = hi_r;
    assign lo         = lo_r;

endmodule
